frame_packer: RTL and testbench
===============================

FRAME_PACKER -- requirements
Module: frame_packer

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 8, giving the width of one data beat.
REQ-002 The block SHALL have a parameter TAG_W, default 4, giving the width of the frame tag.
REQ-003 The block SHALL have a parameter BEATS, default 2, giving the number of data beats per frame; the legal range is BEATS >= 1.
REQ-004 The block SHALL have a parameter TAG_REP, default 2, giving the number of tag copies in the output; the legal range is TAG_REP >= 1.
REQ-005 The block SHALL use the derived width OUT_W = BEATS*DATA_W + TAG_REP*TAG_W.
REQ-006 The block SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have a port rst, input, 1 bit: the synchronous, active-high reset.
REQ-008 The block SHALL have a port in_valid, input, 1 bit: an input beat is offered.
REQ-009 The block SHALL have a port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-010 The block SHALL have a port in_data, input, DATA_W bits: the beat payload.
REQ-011 The block SHALL have a port in_tag, input, TAG_W bits: the frame tag, sampled on the first beat only.
REQ-012 The block SHALL have a port in_last, input, 1 bit: marks the final beat of a short frame.
REQ-013 The block SHALL have a port out_valid, output, 1 bit: the packed frame is available.
REQ-014 The block SHALL have a port out_ready, input, 1 bit: the downstream consumer accepts the frame.
REQ-015 The block SHALL have a port out_data, output, OUT_W bits: the packed frame.
REQ-016 The block SHALL have a port out_short, output, 1 bit: the frame ended via in_last before BEATS beats arrived.

Function
REQ-017 A beat SHALL be accepted on a rising edge where in_valid && in_ready; a frame SHALL be accepted on a rising edge where out_valid && out_ready.
REQ-018 The block SHALL have two states, COLLECT and HOLD; in_ready SHALL be 1 only in COLLECT, and out_valid SHALL be 1 only in HOLD.
REQ-019 In COLLECT, a beat counter cnt (0..BEATS-1) SHALL store each accepted beat into slot cnt and then increment.
REQ-020 The tag SHALL be registered only when the beat is accepted with cnt == 0; in_tag on later beats SHALL be ignored.
REQ-021 On accepting a beat with cnt == BEATS-1, the block SHALL go COLLECT->HOLD, set out_short = 0 and reset cnt to 0.
REQ-022 On accepting a beat with in_last = 1 and cnt < BEATS-1, the block SHALL zero all remaining slots, set out_short = 1, go to HOLD and reset cnt to 0.
REQ-023 If in_last = 1 on a beat with cnt == BEATS-1, REQ-021 SHALL apply and out_short SHALL be 0.
REQ-024 The frame format SHALL be out_data = {slot0, slot1, ..., slot[BEATS-1], {TAG_REP{tag}}}, with slot0 (the first beat) in the MSBs and the replicated tag in the LSBs.
REQ-025 out_data and out_short SHALL be registered and SHALL remain stable while out_valid = 1 && out_ready = 0.
REQ-026 In HOLD, on out_ready = 1, the block SHALL go HOLD->COLLECT; in_ready SHALL NOT rise in the same cycle, so the minimum period is BEATS+1 cycles per full frame.
REQ-027 Input beats offered while in HOLD SHALL NOT be accepted; the upstream holds them.
REQ-028 in_ready and out_valid SHALL depend only on registered state, with no combinational path from inputs.
REQ-029 A BEATS = 1 configuration SHALL pack every accepted beat immediately, and in_last SHALL have no effect.

Reset
REQ-030 While rst = 1 at a rising edge, the state SHALL become COLLECT, cnt = 0, in_ready = 1, out_valid = 0, out_data = 0 and out_short = 0.
REQ-031 A reset during a partial frame or in HOLD SHALL discard that frame, with no frame emitted afterwards.
REQ-032 The block SHALL emit nothing during reset, and it SHALL accept its first beat on the first edge after rst falls.

Verification
REQ-033 Full frame (defaults): beats 8'hFA (tag 4'b0010), then 8'h3C -> out_valid = 1 with out_data = 24'hFA3C22 and out_short = 0, one cycle after the second beat.
REQ-034 Short frame: a single beat 8'hFA with in_last = 1 and tag 4'h2 -> out_data = 24'hFA0022 and out_short = 1.
REQ-035 Tag sampling: beat 1 tag 4'h2, beat 2 tag 4'hF -> out_data[7:0] = 8'h22.
REQ-036 Backpressure: hold out_ready = 0 for 5 cycles -> out_data stays stable, in_ready = 0 and offered beats are not consumed; on out_ready = 1 the frame is consumed and in_ready = 1 on the next cycle.
REQ-037 Reset mid-frame: assert rst after beat 1 -> outputs match REQ-030; the next two beats 8'h11 and 8'h22 with tag 4'h5 -> out_data = 24'h112255.
REQ-038 Parameter sweep: DATA_W=8, TAG_W=4, BEATS=1, TAG_REP=2 with beat 8'hFA and tag 4'h2 -> out_data = 16'hFA22.

Source files
------------

// File: rtl/frame_packer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_packer
//  Brief    : Collects BEATS data beats (or fewer, terminated by in_last) plus
//             a tag sampled on the first beat, and presents them as one packed
//             frame {slot0 .. slot[BEATS-1], {TAG_REP{tag}}} with a valid/ready
//             handshake on each side.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_packer #(
    parameter int DATA_W  = 8,
    parameter int TAG_W   = 4,
    parameter int BEATS   = 2,
    parameter int TAG_REP = 2,
    localparam int OUT_W  = BEATS * DATA_W + TAG_REP * TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    // upstream beat interface
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              in_last,
    // downstream frame interface
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_short
);

    // A single-beat configuration still needs a 1-bit counter to keep the
    // declarations legal; it simply never leaves zero.
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [TAG_W-1:0]   r_tag;
    logic               r_out_short;
    logic [DATA_W-1:0]  r_slot [BEATS];

    logic               w_beat_acc;
    logic               w_at_last;
    logic               w_short;
    logic               w_frame_end;
    logic               w_frame_acc;

    // Handshake flags come straight from the state register, so neither
    // ready nor valid has a combinational path from the inputs.
    assign in_ready  = (r_state == COLLECT);
    assign out_valid = (r_state == HOLD);
    assign out_short = r_out_short;

    // Beat/frame acceptance decode and next-state selection.
    always_comb begin
        w_beat_acc   = 1'b0;
        w_at_last    = 1'b0;
        w_short      = 1'b0;
        w_frame_end  = 1'b0;
        w_frame_acc  = 1'b0;
        w_state_next = r_state;

        w_at_last = (r_cnt == c_last_cnt);

        case (r_state)
            COLLECT: begin
                w_beat_acc = in_valid;
                // in_last on the final slot is a normal full frame, so a
                // frame is only short when it ends before the last slot.
                w_short     = in_last && !w_at_last;
                w_frame_end = w_beat_acc && (w_at_last || in_last);
                if (w_frame_end) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                w_frame_acc = out_ready;
                if (w_frame_acc) begin
                    w_state_next = COLLECT;
                end
            end
            default: begin
                w_state_next = COLLECT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Beat counter: advances per accepted beat, returns to zero at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_frame_end) begin
            r_cnt <= '0;
        end else if (w_beat_acc) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    // Tag is captured on the first beat of a frame only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag <= '0;
        end else if (w_beat_acc && (r_cnt == '0)) begin
            r_tag <= in_tag;
        end
    end

    // Short-frame flag is updated once per frame, at the closing beat, and
    // then holds while the frame waits downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_short <= 1'b0;
        end else if (w_frame_end) begin
            r_out_short <= w_short;
        end
    end

    // One register per beat slot. The accepted beat lands in slot cnt; on a
    // short frame every slot beyond the closing beat is cleared so stale data
    // from an earlier frame never leaks into the packed output.
    for (genvar i = 0; i < BEATS; i++) begin : g_slot
        localparam logic [CNT_W-1:0] c_idx = CNT_W'(i);

        // Slot i capture / zero-fill.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_slot[i] <= '0;
            end else if (w_beat_acc) begin
                if (r_cnt == c_idx) begin
                    r_slot[i] <= in_data;
                end else if (w_short && (c_idx > r_cnt)) begin
                    r_slot[i] <= '0;
                end
            end
        end

        // Slot 0 sits in the most significant bits of the frame.
        assign out_data[OUT_W - 1 - i * DATA_W -: DATA_W] = r_slot[i];
    end

    // Replicated tag fills the least significant bits. Slots and tag are all
    // registers and are not written while in HOLD, so the frame is stable
    // for as long as the consumer stalls.
    for (genvar j = 0; j < TAG_REP; j++) begin : g_tag
        assign out_data[j * TAG_W +: TAG_W] = r_tag;
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_packer
//  Brief    : Self-checking bench for frame_packer: table of frames in the
//             default configuration plus hand-written sequences for
//             backpressure, reset mid-frame / in HOLD, and a BEATS=1 build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_packer;

    logic        clk;
    logic        rst;

    // default configuration: DATA_W=8, TAG_W=4, BEATS=2, TAG_REP=2
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [3:0]  in_tag;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        out_short;

    // single-beat configuration
    logic        b1_in_valid;
    logic        b1_in_ready;
    logic [7:0]  b1_in_data;
    logic [3:0]  b1_in_tag;
    logic        b1_in_last;
    logic        b1_out_valid;
    logic        b1_out_ready;
    logic [15:0] b1_out_data;
    logic        b1_out_short;

    int n_checks = 0;
    int n_fail   = 0;

    frame_packer #(
        .DATA_W (8),
        .TAG_W  (4),
        .BEATS  (2),
        .TAG_REP(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_tag   (in_tag),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_short(out_short)
    );

    frame_packer #(
        .DATA_W (8),
        .TAG_W  (4),
        .BEATS  (1),
        .TAG_REP(2)
    ) dut_b1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (b1_in_valid),
        .in_ready (b1_in_ready),
        .in_data  (b1_in_data),
        .in_tag   (b1_in_tag),
        .in_last  (b1_in_last),
        .out_valid(b1_out_valid),
        .out_ready(b1_out_ready),
        .out_data (b1_out_data),
        .out_short(b1_out_short)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [23:0] data;
        logic        short_f;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        int          nbeats;
        logic [7:0]  d0;
        logic [3:0]  t0;
        logic        l0;
        logic [7:0]  d1;
        logic [3:0]  t1;
        logic        l1;
        logic [23:0] exp_data;
        logic        exp_short;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one beat starting at a negedge; returns at the negedge after it
    // was accepted, with in_valid dropped.
    task automatic send_beat(input logic [7:0] d, input logic [3:0] t, input logic l,
                             output int waited);
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        in_last  = l;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_accept_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for a frame, compare it against the scoreboard head, consume it.
    task automatic recv_frame(input string name);
        int   n;
        exp_t e;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got out_valid=0 expected 1 within 50 cycles", name);
        end else if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_unexpected: got frame %0h expected no frame", name, out_data);
        end else begin
            e = sb_q.pop_front();
            check({name, "_data"}, 64'(out_data), 64'(e.data));
            check({name, "_short"}, 64'(out_short), 64'(e.short_f));
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int   w;
        exp_t e;

        // nbeats, d0, t0, l0, d1, t1, l1, expected frame, expected short
        vecs[0] = '{2, 8'hFA, 4'h2, 1'b0, 8'h3C, 4'h2, 1'b0, 24'hFA3C22, 1'b0}; // full frame
        vecs[1] = '{1, 8'hFA, 4'h2, 1'b1, 8'h00, 4'h0, 1'b0, 24'hFA0022, 1'b1}; // short frame
        vecs[2] = '{2, 8'hAB, 4'h2, 1'b0, 8'hCD, 4'hF, 1'b0, 24'hABCD22, 1'b0}; // tag on beat 1 only
        vecs[3] = '{2, 8'h55, 4'h7, 1'b0, 8'h66, 4'h1, 1'b1, 24'h556677, 1'b0}; // last on final slot
        vecs[4] = '{2, 8'h00, 4'hA, 1'b0, 8'hFF, 4'h0, 1'b0, 24'h00FFAA, 1'b0};
        vecs[5] = '{1, 8'h3C, 4'hF, 1'b1, 8'h00, 4'h0, 1'b0, 24'h3C00FF, 1'b1}; // zero-fills stale slot1

        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        in_tag       = 4'h0;
        in_last      = 1'b0;
        out_ready    = 1'b0;
        b1_in_valid  = 1'b0;
        b1_in_data   = 8'h00;
        b1_in_tag    = 4'h0;
        b1_in_last   = 1'b0;
        b1_out_ready = 1'b1;

        // Reset state, with a beat offered during reset that must be ignored.
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h99;
        in_tag   = 4'h9;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_short", 64'(out_short), 64'd0);
        check("rst_b1_out_data", 64'(b1_out_data), 64'd0);
        in_valid = 1'b0;
        rst      = 1'b0;

        // Table of frames; the first beat also proves acceptance on the
        // first edge after reset release.
        for (int i = 0; i < 6; i++) begin
            e.data    = vecs[i].exp_data;
            e.short_f = vecs[i].exp_short;
            sb_q.push_back(e);
            send_beat(vecs[i].d0, vecs[i].t0, vecs[i].l0, w);
            if (i == 0) check("first_beat_wait", 64'(w), 64'd0);
            if (vecs[i].nbeats == 2) send_beat(vecs[i].d1, vecs[i].t1, vecs[i].l1, w);
            check($sformatf("vec%0d_valid_latency", i), 64'(out_valid), 64'd1);
            recv_frame($sformatf("vec%0d", i));
        end

        // Backpressure: frame held 5 cycles with a beat offered meanwhile.
        e.data    = 24'h123433;
        e.short_f = 1'b0;
        sb_q.push_back(e);
        send_beat(8'h12, 4'h3, 1'b0, w);
        send_beat(8'h34, 4'h3, 1'b0, w);
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_tag   = 4'hE;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_out_valid", c), 64'(out_valid), 64'd1);
            check($sformatf("bp%0d_in_ready", c),  64'(in_ready),  64'd0);
            check($sformatf("bp%0d_out_data", c),  64'(out_data),  64'h123433);
            check($sformatf("bp%0d_out_short", c), 64'(out_short), 64'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        check("bp_release_in_ready", 64'(in_ready), 64'd0);
        e = sb_q.pop_front();
        check("bp_release_data", 64'(out_data), 64'(e.data));
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_after_out_valid", 64'(out_valid), 64'd0);
        check("bp_after_in_ready",  64'(in_ready),  64'd1);

        // Reset mid-frame: the partial frame must vanish.
        send_beat(8'hAA, 4'h1, 1'b0, w);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rmid_in_ready",  64'(in_ready),  64'd1);
        check("rmid_out_valid", 64'(out_valid), 64'd0);
        check("rmid_out_data",  64'(out_data),  64'd0);
        check("rmid_out_short", 64'(out_short), 64'd0);
        e.data    = 24'h112255;
        e.short_f = 1'b0;
        sb_q.push_back(e);
        send_beat(8'h11, 4'h5, 1'b0, w);
        send_beat(8'h22, 4'h5, 1'b0, w);
        recv_frame("rmid");

        // Reset while a frame is held: nothing is emitted afterwards.
        send_beat(8'hC1, 4'h4, 1'b1, w);
        check("rhold_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rhold%0d_out_valid", c), 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b0;

        // Single-beat build: every beat is a full frame, in_last ignored.
        for (int k = 0; k < 2; k++) begin
            b1_in_valid = 1'b1;
            b1_in_data  = (k == 0) ? 8'hFA : 8'h3C;
            b1_in_tag   = (k == 0) ? 4'h2  : 4'h5;
            b1_in_last  = (k == 1);
            check($sformatf("b1_%0d_in_ready", k), 64'(b1_in_ready), 64'd1);
            @(posedge clk);
            @(negedge clk);
            b1_in_valid = 1'b0;
            b1_in_last  = 1'b0;
            check($sformatf("b1_%0d_out_valid", k), 64'(b1_out_valid), 64'd1);
            check($sformatf("b1_%0d_out_data", k),  64'(b1_out_data),
                  (k == 0) ? 64'hFA22 : 64'h3C55);
            check($sformatf("b1_%0d_out_short", k), 64'(b1_out_short), 64'd0);
            @(negedge clk);
        end

        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
